// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master bus arbiter with registered one-hot grant, address-phase timeout and multi-cycle strobe.
// Define BUS_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins priority instead of round-robin.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS     = 4,
  parameter int CLK_MAX_TIMEOUT = 12,
  parameter int STROBE_CYCLES   = 1,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         barq_i,
  output logic [NUM_MASTERS-1:0]         bagd_o,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_idx_o,
  output logic                           target_ready_o,
  input  logic                           address_valid_i,
  output logic                           data_strobe_o,
  output logic                           busy_o,
  output logic                           error_o,
  output logic [CNT_WIDTH-1:0]           error_cnt_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(CLK_MAX_TIMEOUT - 1);
  localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);
  logic [2:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] bagd_q, bagd_d;
  logic [IW-1:0]          idx_q, idx_d, win;
  logic [CNT_WIDTH-1:0]   tmo_q, tmo_d, ecnt_q, ecnt_d;
  logic [3:0]             stb_q, stb_d;
  logic                   err_q, err_d;
`ifdef BUS_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (barq_i[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  // Scan downward so the last hit is the first requester at or after the pointer.
  always_comb begin
    win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (barq_i[j]) win = IW'(j);
    end
  end
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && |barq_i) ptr_d = (win == IW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk)
    ptr_q <= reset ? '0 : ptr_d;
`endif
  always_comb begin
    state_d = state_q;
    bagd_d  = bagd_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    stb_d   = stb_q;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      S_IDLE: if (|barq_i) begin
        state_d = S_GRANT;
        bagd_d  = NUM_MASTERS'(1) << win;
        idx_d   = win;
      end
      S_GRANT: begin
        state_d = S_ADDR;
        tmo_d   = '0;
      end
      S_ADDR: begin
        tmo_d = tmo_q + 1'b1;
        if (address_valid_i) begin
          state_d = S_STROBE;
          stb_d   = '0;
        end else if (!barq_i[idx_q]) begin
          state_d = S_RELEASE;
          bagd_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_STROBE: begin
        stb_d = stb_q + 1'b1;
        if (stb_q == STB_LAST) begin
          state_d = S_RELEASE;
          bagd_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_ERROR: begin
        state_d = S_RELEASE;
        bagd_d  = '0;
        err_d   = 1'b1;
        ecnt_d  = &ecnt_q ? ecnt_q : ecnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        bagd_d  = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bagd_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      stb_q   <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bagd_q  <= bagd_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end
  assign bagd_o         = bagd_q;
  assign grant_idx_o    = idx_q;
  assign target_ready_o = (state_q == S_ADDR) || (state_q == S_STROBE);
  assign data_strobe_o  = state_q == S_STROBE;
  assign busy_o         = state_q != S_IDLE;
  assign error_o        = err_q;
  assign error_cnt_o    = ecnt_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed bench for bus_arbiter_rr (default build and BUS_ARBITER_FIXED_PRIORITY_EN).
module tb_bus_arbiter_rr;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] barq_i = '0;
  logic       address_valid_i = 1'b0;
  logic [3:0] bagd_o, bagd3_o;
  logic [1:0] grant_idx_o, grant_idx3_o;
  logic       target_ready_o, data_strobe_o, busy_o, error_o;
  logic       target_ready3_o, data_strobe3_o, busy3_o, error3_o;
  logic [7:0] error_cnt_o, error_cnt3_o;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  bus_arbiter_rr #(.NUM_MASTERS(4), .CLK_MAX_TIMEOUT(12), .STROBE_CYCLES(1), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .barq_i(barq_i), .bagd_o(bagd_o), .grant_idx_o(grant_idx_o),
    .target_ready_o(target_ready_o), .address_valid_i(address_valid_i), .data_strobe_o(data_strobe_o),
    .busy_o(busy_o), .error_o(error_o), .error_cnt_o(error_cnt_o));
  bus_arbiter_rr #(.NUM_MASTERS(4), .CLK_MAX_TIMEOUT(12), .STROBE_CYCLES(3), .CNT_WIDTH(8)) u_dut3 (
    .clk(clk), .reset(reset), .barq_i(barq_i), .bagd_o(bagd3_o), .grant_idx_o(grant_idx3_o),
    .target_ready_o(target_ready3_o), .address_valid_i(address_valid_i), .data_strobe_o(data_strobe3_o),
    .busy_o(busy3_o), .error_o(error3_o), .error_cnt_o(error_cnt3_o));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    barq_i = '0;
    address_valid_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    checks++; if ({bagd_o, grant_idx_o} !== 6'b0) begin errors++; $display("FAIL reset_grant: got %b exp 000000", {bagd_o, grant_idx_o}); end
    checks++; if ({target_ready_o, data_strobe_o, busy_o} !== 3'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 000", {target_ready_o, data_strobe_o, busy_o}); end
    checks++; if ({error_o, error_cnt_o} !== 9'b0) begin errors++; $display("FAIL reset_err: got %h exp 000", {error_o, error_cnt_o}); end
  endtask
  task automatic test_single;
    barq_i = 4'b0001;
    tick();
    checks++; if ({bagd_o, grant_idx_o, busy_o, target_ready_o} !== 8'b0001_00_1_0) begin errors++; $display("FAIL single_grant: got %b exp 00010010", {bagd_o, grant_idx_o, busy_o, target_ready_o}); end
    tick();
    checks++; if ({target_ready_o, data_strobe_o} !== 2'b10) begin errors++; $display("FAIL single_addr1: got %b exp 10", {target_ready_o, data_strobe_o}); end
    tick();
    checks++; if ({target_ready_o, data_strobe_o} !== 2'b10) begin errors++; $display("FAIL single_addr2: got %b exp 10", {target_ready_o, data_strobe_o}); end
    address_valid_i = 1'b1;
    tick();
    checks++; if ({bagd_o, target_ready_o, data_strobe_o} !== 6'b0001_11) begin errors++; $display("FAIL single_strobe: got %b exp 000111", {bagd_o, target_ready_o, data_strobe_o}); end
    address_valid_i = 1'b0;
    barq_i = '0;
    tick();
    checks++; if ({bagd_o, target_ready_o, data_strobe_o, busy_o} !== 7'b0000_001) begin errors++; $display("FAIL single_release: got %b exp 0000001", {bagd_o, target_ready_o, data_strobe_o, busy_o}); end
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b exp 0", busy_o); end
  endtask
  task automatic test_round_robin;
    logic [3:0] exp_g;
    do_reset();
    barq_i = 4'b1111;
    address_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef BUS_ARBITER_FIXED_PRIORITY_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      tick();
      checks++; if (bagd_o !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, bagd_o, exp_g); end
      tick();
      tick();
      checks++; if ({bagd_o, data_strobe_o} !== {exp_g, 1'b1}) begin errors++; $display("FAIL rr_strobe%0d: got %b exp %b1", k, {bagd_o, data_strobe_o}, exp_g); end
      tick();
      tick();
      checks++; if ({bagd_o, busy_o} !== 5'b0) begin errors++; $display("FAIL rr_gap%0d: got %b exp 00000", k, {bagd_o, busy_o}); end
    end
    barq_i = '0;
    address_valid_i = 1'b0;
    tick();
  endtask
  task automatic test_timeout;
    int tr_cnt = 0;
    int ds_cnt = 0;
    do_reset();
    barq_i = 4'b0001;
    tick();
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (target_ready_o) tr_cnt++;
      if (data_strobe_o) ds_cnt++;
      if (i == 13) begin
        checks++; if ({bagd_o, busy_o, error_o} !== 6'b0001_1_0) begin errors++; $display("FAIL tmo_errstate: got %b exp 000110", {bagd_o, busy_o, error_o}); end
      end
    end
    checks++; if (tr_cnt !== 12) begin errors++; $display("FAIL tmo_ready_cycles: got %0d exp 12", tr_cnt); end
    checks++; if (ds_cnt !== 0) begin errors++; $display("FAIL tmo_no_strobe: got %0d exp 0", ds_cnt); end
    checks++; if ({error_o, error_cnt_o} !== 9'h101) begin errors++; $display("FAIL tmo_error: got %h exp 101", {error_o, error_cnt_o}); end
    barq_i = '0;
    tick();
    barq_i = 4'b0001;
    address_valid_i = 1'b1;
    tick();
    tick();
    tick();
    checks++; if ({data_strobe_o, error_o} !== 2'b11) begin errors++; $display("FAIL tmo_err_held: got %b exp 11", {data_strobe_o, error_o}); end
    barq_i = '0;
    address_valid_i = 1'b0;
    tick();
    checks++; if ({error_o, error_cnt_o} !== 9'h001) begin errors++; $display("FAIL tmo_err_clear: got %h exp 001", {error_o, error_cnt_o}); end
    tick();
  endtask
  task automatic test_drop;
    do_reset();
    barq_i = 4'b0011;
    tick();
    checks++; if (bagd_o !== 4'b0001) begin errors++; $display("FAIL drop_grant0: got %b exp 0001", bagd_o); end
    tick();
    tick();
    tick();
    barq_i = 4'b0010;
    tick();
    checks++; if ({bagd_o, busy_o, target_ready_o, data_strobe_o, error_o} !== 8'b0000_1000) begin errors++; $display("FAIL drop_release: got %b exp 00001000", {bagd_o, busy_o, target_ready_o, data_strobe_o, error_o}); end
    tick();
    checks++; if ({bagd_o, busy_o, grant_idx_o} !== 7'b0000_0_00) begin errors++; $display("FAIL drop_idle: got %b exp 0000000", {bagd_o, busy_o, grant_idx_o}); end
    tick();
    checks++; if ({bagd_o, grant_idx_o} !== 6'b0010_01) begin errors++; $display("FAIL drop_next: got %b exp 001001", {bagd_o, grant_idx_o}); end
    barq_i = '0;
    tick();
    tick();
    tick();
  endtask
  task automatic test_strobe3;
    int ds_cnt = 0;
    do_reset();
    barq_i = 4'b0001;
    address_valid_i = 1'b1;
    tick();
    tick();
    tick();
    checks++; if ({data_strobe3_o, target_ready3_o} !== 2'b11) begin errors++; $display("FAIL s3_start: got %b exp 11", {data_strobe3_o, target_ready3_o}); end
    ds_cnt = 1;
    barq_i = '0;
    address_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (data_strobe3_o) ds_cnt++;
    end
    checks++; if (ds_cnt !== 3) begin errors++; $display("FAIL s3_len: got %0d exp 3", ds_cnt); end
    checks++; if (busy3_o !== 1'b0) begin errors++; $display("FAIL s3_idle: busy got %b exp 0", busy3_o); end
  endtask
  task automatic test_reset_mid;
    barq_i = 4'b1111;
    address_valid_i = 1'b1;
    tick();
`ifndef BUS_ARBITER_FIXED_PRIORITY_EN
    checks++; if (bagd_o !== 4'b0010) begin errors++; $display("FAIL rm_grant1: got %b exp 0010", bagd_o); end
`endif
    tick();
    tick();
    checks++; if (data_strobe_o !== 1'b1) begin errors++; $display("FAIL rm_strobe: got %b exp 1", data_strobe_o); end
    reset = 1'b1;
    tick();
    checks++; if ({bagd_o, grant_idx_o, target_ready_o, data_strobe_o, busy_o, error_o} !== 10'b0) begin errors++; $display("FAIL rm_outputs: got %b exp 0000000000", {bagd_o, grant_idx_o, target_ready_o, data_strobe_o, busy_o, error_o}); end
    reset = 1'b0;
    tick();
    checks++; if ({bagd_o, grant_idx_o} !== 6'b0001_00) begin errors++; $display("FAIL rm_regrant: got %b exp 000100", {bagd_o, grant_idx_o}); end
    barq_i = '0;
    address_valid_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_drop();
    test_strobe3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor to the main-bus master arbiter: N masters, registered one-hot grant, address-phase timeout with sticky error, multi-cycle data strobe.
- Round-robin fairness by default; fixed priority selectable at compile time.
- Sits between master interfaces (USB interface and future masters) and the address decoder / dev_sel logic of the main 16-bit bus.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
CLK_MAX_TIMEOUT, 12, max clk cycles in address phase waiting for address_valid_i
STROBE_CYCLES, 1, width of data_strobe_o pulse in clk cycles (1..15)
CNT_WIDTH, 8, width of timeout and error counters

Ports:
clk  input  1  system clock (100 MHz bus clock)
reset  input  1  synchronous, active-high reset
barq_i  input  NUM_MASTERS  bus access request, one bit per master, level
bagd_o  output  NUM_MASTERS  bus grant, one-hot or zero, registered
grant_idx_o  output  $clog2(NUM_MASTERS)  index of current/last granted master
target_ready_o  output  1  enables address decode; dev_sel must clear when low
address_valid_i  input  1  OR of registered dev_sel; a target claimed the address
data_strobe_o  output  1  data transfer strobe to selected target
busy_o  output  1  high in any state other than IDLE
error_o  output  1  sticky timeout flag
error_cnt_o  output  CNT_WIDTH  saturating count of timeouts

Behaviour:
- Reset (sync, active-high): state IDLE; bagd_o=0, grant_idx_o=0, target_ready_o=0, data_strobe_o=0, busy_o=0, error_o=0, error_cnt_o=0; RR pointer=0. Reset mid-transaction aborts with no strobe; all outputs 0 after the reset edge.
- States: IDLE, GRANT, ADDR, STROBE, ERROR, RELEASE.
- IDLE: if |barq_i, select winner. Next cycle: GRANT, bagd_o one-hot for winner, grant_idx_o=winner.
- RR selection: first requesting index at or after pointer, wrapping modulo NUM_MASTERS. Pointer loads winner+1 (wrap to 0 after NUM_MASTERS-1) on entering GRANT.
- GRANT: exactly 1 cycle of address settle; target_ready_o=0. Then ADDR.
- ADDR: target_ready_o=1; timeout counter cleared on entry, +1 per cycle.
  - address_valid_i=1: next state STROBE.
  - address_valid_i=0 after CLK_MAX_TIMEOUT ADDR cycles (counter==CLK_MAX_TIMEOUT-1 at the sampling edge): next state ERROR.
  - Granted master's barq_i bit low: next state RELEASE, no strobe, no error. This check has priority over timeout; address_valid_i has priority over both.
- STROBE: data_strobe_o=1 and target_ready_o=1 for exactly STROBE_CYCLES cycles, then RELEASE. barq_i is ignored during STROBE; a started strobe always completes.
- ERROR: 1 cycle; error_o<=1; error_cnt_o +1, saturating at all-ones. Then RELEASE.
- RELEASE: 1 cycle; bagd_o=0, target_ready_o=0, data_strobe_o=0. Then IDLE.
- Minimum gap: one IDLE cycle between grants.
- Grant-to-strobe latency with immediate address_valid_i is 2 cycles after bagd_o rises.
- error_o clears only on reset or on completion of a subsequent successful STROBE.
- bagd_o is stable for the whole GRANT..STROBE/ERROR span.
- bagd_o is never multi-hot. grant_idx_o holds its value in IDLE.

Optional Feature:
- Macro: BUS_ARBITER_FIXED_PRIORITY_EN.
- Defined: winner is always the lowest-index requesting master; RR pointer is not implemented.
- Undefined: round-robin as above.
- State machine, timing and error handling are identical in both builds.

Test Plan:
- NUM_MASTERS=4, barq_i=4'b0001, address_valid_i rises 1 cycle after target_ready_o -> bagd_o=0001; data_strobe_o high 1 cycle; RELEASE; busy_o low 5 cycles after request seen.
- barq_i=4'b1111 held, address_valid_i always 1 -> grant order 0,1,2,3,0. With BUS_ARBITER_FIXED_PRIORITY_EN, grant is 0 every time.
- address_valid_i held 0, CLK_MAX_TIMEOUT=12 -> target_ready_o high exactly 12 cycles; error_o=1; error_cnt_o=1; no data_strobe_o. A following good transaction clears error_o; error_cnt_o stays 1.
- Granted master drops barq_i on 3rd ADDR cycle -> RELEASE next; no strobe; error_o=0; next requester granted after 1 IDLE cycle.
- STROBE_CYCLES=3, master drops barq_i during STROBE -> data_strobe_o high exactly 3 cycles.
- reset asserted during STROBE -> next cycle all outputs 0, state IDLE; RR pointer returns to 0, so master 0 wins next with barq_i=1111.
